// File: rtl/sha3_pkg.sv
// Shared SHA3 definitions: word/digest widths, unpacker state encoding and
// helpers that derive word count and final-word byte count from a digest length.
package sha3_pkg;

   localparam int WORD_W   = 64;
   localparam int DIGEST_W = 512;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic int words_of(input int outBits);
      return (outBits + 32'd63) / 32'd64;
   endfunction

   // 0 means the final word carries all 8 bytes
   function automatic int last_bytes_of(input int outBits);
      return (outBits / 32'd8) % 32'd8;
   endfunction

endpackage

// File: rtl/digest_unpacker_if.sv
// Digest capture and word-stream signals between f_permutation, unpacker and user.
interface digest_unpacker_if;
   import sha3_pkg::*;

   logic [DIGEST_W-1:0] iDigest;
   logic                iDigest_valid;
   logic                oDigest_ack;
   logic [WORD_W-1:0]   oData;
   logic                oValid;
   logic                oLast;
   logic [2:0]          oByte_num;
   logic                iAck;
   logic                oBusy;

   modport master (
      input  iDigest, iDigest_valid, iAck,
      output oDigest_ack, oData, oValid, oLast, oByte_num, oBusy
   );

   modport slave (
      output iDigest, iDigest_valid, iAck,
      input  oDigest_ack, oData, oValid, oLast, oByte_num, oBusy
   );
endinterface

// File: rtl/digest_unpacker_last_word_mask.sv
// Keeps the leading byteNum bytes of a word (MSB-aligned) and zeroes the rest;
// byteNum of 0 passes the whole word.
module last_word_mask
   import sha3_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [2:0]        byteNum,
   output logic [WORD_W-1:0] masked
);

   // per-byte keep/clear selection, byte 0 being the most significant
   always_comb begin
      masked = {WORD_W{1'b0}};
      for (int b = 0; b < 8; b++) begin
         if ((byteNum == 3'd0) || (3'(b) < byteNum)) begin
            masked[WORD_W-1-8*b -: 8] = word[WORD_W-1-8*b -: 8];
         end else begin
            masked[WORD_W-1-8*b -: 8] = 8'h00;
         end
      end
   end

endmodule

// File: rtl/digest_unpacker.sv
// Captures a 512-bit digest and streams it out as 64-bit words, MSW first,
// with valid/last/byte_num framing; a new digest may load on the final-word accept.
module digest_unpacker
   import sha3_pkg::*;
#(
   parameter int OUT_BITS = 512
) (
   input logic              iClk,
   input logic              iRst_n,
   digest_unpacker_if.master bus
);

   localparam logic [2:0] LAST_CNT   = 3'(words_of(OUT_BITS) - 1);
   localparam logic [2:0] LAST_BYTES = 3'(last_bytes_of(OUT_BITS));

   state_t              state;
   state_t              stateNext;
   logic [2:0]          cnt;
   logic [DIGEST_W-1:0] shreg;
   logic                isLast;
   logic                cap;
   logic                advance;
   logic [2:0]          byteNum;

   // capture/advance decisions and next state
   always_comb begin
      stateNext = state;
      isLast    = (state == SEND) && (cnt == LAST_CNT);
      cap       = iRst_n && bus.iDigest_valid &&
                  ((state == IDLE) || (isLast && bus.iAck));
      advance   = (state == SEND) && bus.iAck && !isLast;
      case (state)
         IDLE: begin
            if (cap) begin
               stateNext = SEND;
            end else begin
               stateNext = IDLE;
            end
         end
         SEND: begin
            if (isLast && bus.iAck) begin
               stateNext = cap ? SEND : IDLE;
            end else begin
               stateNext = SEND;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // state, word counter and digest shift register
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state <= IDLE;
         cnt   <= 3'd0;
         shreg <= {DIGEST_W{1'b0}};
      end else begin
         state <= stateNext;
         if (cap) begin
            cnt   <= 3'd0;
            shreg <= bus.iDigest;
         end else if (advance) begin
            cnt   <= cnt + 3'd1;
            shreg <= {shreg[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
         end else begin
            cnt   <= cnt;
            shreg <= shreg;
         end
      end
   end

   // framing outputs, all derived from registered state
   always_comb begin
      if (isLast) begin
         byteNum = LAST_BYTES;
      end else begin
         byteNum = 3'd0;
      end
      bus.oValid      = (state == SEND);
      bus.oBusy       = (state == SEND);
      bus.oLast       = isLast;
      bus.oByte_num   = byteNum;
      bus.oDigest_ack = cap;
   end

   last_word_mask uMask (
      .word    (shreg[DIGEST_W-1 -: WORD_W]),
      .byteNum (byteNum),
      .masked  (bus.oData)
   );

endmodule

// File: doc/digest_unpacker.md
# digest_unpacker

Output-side counterpart of the SHA3 input padder. It captures the 512-bit digest presented by the f_permutation core and streams it to the user module as 64-bit words, most-significant word first. The stream uses the same valid/last/byte_num conventions the padder accepts on its input. The block sits between the f_permutation output and the user/bus wrapper, and it frees the core's output register as soon as the digest has been captured.

## Interface
- OUT_BITS, 512, digest length delivered; legal values 224, 256, 384, 512.
- WORDS, derived, ceil(OUT_BITS/64): 4, 4, 6, 8.
- LAST_BYTES, derived, (OUT_BITS/8) mod 8: 4 for 224, else 0 (0 means 8 bytes).

- iClk  in  1  clock; all logic on rising edge.
- iRst_n  in  1  reset; synchronous, active-low.
- iDigest  in  512  digest from f_permutation; bit 511 is the first output bit.
- iDigest_valid  in  1  level; digest on iDigest is valid.
- oDigest_ack  out  1  combinational pulse; digest captured this edge.
- oData  out  64  current output word.
- oValid  out  1  oData is valid.
- oLast  out  1  current word is the final word of the digest.
- oByte_num  out  3  valid bytes in the last word, MSB-aligned; 0 means 8 and when oLast=0.
- iAck  in  1  consumer takes the word on an edge where oValid & iAck.
- oBusy  out  1  a digest is held, i.e. state is SEND.

## Operation
- **States:**
  - IDLE: oValid=0.
  - SEND: oValid=1.
- **Capture condition:** cap = iDigest_valid & (IDLE | (SEND & oLast & iAck)).
  - oDigest_ack = cap.
  - On cap: shift register ← iDigest, word counter cnt ← 0, state ← SEND.
- **Output word:** oData = shreg[511:448].
  - When oLast and LAST_BYTES≠0, the low (8−LAST_BYTES) bytes are forced to 0.
- **Advance:** in SEND with iAck and not oLast, shreg shifts left by 64 (zero fill) and cnt increments.
- **oLast:** oLast = SEND & (cnt == WORDS−1).
- **oByte_num:** LAST_BYTES when oLast, else 0.
- **Final word accepted:**
  - Without cap: state ← IDLE.
  - With cap: state stays SEND, the new digest is loaded and cnt=0. There is no bubble.
- **Unsolicited ack:** iAck while IDLE is ignored.
- **Holding data:** iDigest_valid while in SEND (other than the final-accept edge) is not acked. The core must hold its data until oDigest_ack.
- **Counter width:** cnt is 3 bits and never exceeds WORDS−1. No wrap beyond the final word.

## Timing
- **Reset (iRst_n=0 at an edge):**
  - state=IDLE, cnt=0, shreg=0.
  - Outputs: oValid=0, oLast=0, oByte_num=0, oBusy=0, oData=0.
  - oDigest_ack is held 0 while iRst_n=0.
  - Reset mid-stream discards the remaining words.
- **Latency:** cap at edge N gives oValid=1 with the first word from cycle N+1.
- **Throughput:** one word per cycle while iAck=1. A full SHA3-512 digest takes 8 cycles. Back-to-back digests are gap-free.
- **Output stability:** oData, oLast and oByte_num are registered-stable while oValid=1 & iAck=0.
- **Ack path:** oDigest_ack depends combinationally on iDigest_valid, iAck and the state. There is no path from iDigest to outputs.

## Structure
- **Shared package `sha3_pkg`:** holds the 64-bit word width, the 512-bit digest width, the state encoding (IDLE, SEND), and the functions words_of(OUT_BITS) and last_bytes_of(OUT_BITS).
- **Sub-module `last_word_mask`:** combinational; maps (word, byte_num) to the MSB-aligned masked word. It is the mirror of the padder's byte-number handling.
- **Top-level contents:** FSM, counter, shift register.

## Test plan
- **Reset, then SHA3-512 digest:** apply iRst_n=0, then set iDigest=0x00..3F byte pattern (byte k = k), iDigest_valid=1, iAck=1.
  - oDigest_ack pulses one cycle.
  - 8 words follow, first = 0x0001020304050607 and last = 0x38393A3B3C3D3E3F.
  - oLast only on the 8th word, with oByte_num=0.
- **OUT_BITS=224, same digest:**
  - 4 words, the 4th = 0x18191A1B00000000 with oLast=1 and oByte_num=4.
  - oBusy drops the next cycle.
- **Backpressure:** with iAck=0 for 5 cycles after the first word:
  - oData stays 0x0001020304050607 and oValid stays 1.
  - Resuming iAck delivers the remaining words unchanged.
- **Back-to-back digests:** iDigest_valid held high with a second digest of all 0xFF bytes.
  - oDigest_ack is asserted on the same edge the final word of digest 1 is accepted.
  - The next cycle shows 0xFFFFFFFFFFFFFFFF with cnt=0 and no idle cycle.
- **Reset mid-stream:** assert iRst_n=0 after word 3.
  - oValid=0 the next cycle.
  - A new digest afterward starts from word 0.
- **Ignored inputs:** iAck pulses in IDLE, and iDigest_valid in SEND mid-stream.
  - No state change, and no oDigest_ack until the final word is accepted.
